multicycle_main_control: RTL and testbench
==========================================

// Module: multicycle_main_control
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath; the producer side of the AluOP interface decoded downstream by the ALU control block.
//  Steps fetch/decode/execute/memory/writeback per instruction from Opcode, with a MemReady wait handshake on memory states.
//  Outputs are Moore, decoded from the state register. AluOP: 00=add, 01=sub, 10=use Func.
// PARAMETERS
//  CNT_W     32         width of InstrRetired counter
//  OP_RTYPE  6'b000000  R-type opcode
//  OP_LW     6'b100011  load word
//  OP_SW     6'b101011  store word
//  OP_BEQ    6'b000100  branch equal
//  OP_ADDI   6'b001000  add immediate
//  OP_J      6'b000010  jump
// PORTS
//  Clk           in   1      clock, rising edge
//  Rst_n         in   1      asynchronous active-low reset
//  Opcode        in   6      IR[31:26], valid from DECODE onward
//  Zero          in   1      ALU zero flag
//  MemReady      in   1      memory completes the current access this cycle
//  AluOP         out  2      to ALU control
//  AluSrcA       out  1      0=PC, 1=A
//  AluSrcB       out  2      00=B, 01=4, 10=SignImm, 11=SignImm<<2
//  PCSrc         out  2      00=ALU result, 01=ALUOut, 10=jump target
//  PCEn          out  1      PCWrite | (Branch & Zero)
//  IRWrite, MemRead, MemWrite, IorD, RegWrite, RegDst, MemtoReg  out 1 each  datapath strobes/selects
//  IllegalOp     out  1      one-cycle pulse on unsupported opcode
//  InstrRetired  out  CNT_W  count of completed instructions
// BEHAVIOUR
//  States: RESET, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
//  Rst_n low (any time, mid-instruction included): state=RESET, InstrRetired=0, IllegalOp=0, all outputs 0.
//  RESET: all outputs 0; next state is FETCH unconditionally.
//  FETCH: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, AluOP=00, PCSrc=00.
//    IRWrite=PCWrite=MemReady. Stay while MemReady=0; go to DECODE when MemReady=1.
//  DECODE: AluSrcA=0, AluSrcB=11, AluOP=00. Next state by Opcode:
//    LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP.
//    Any other opcode -> FETCH, with IllegalOp=1 for exactly that cycle; InstrRetired not incremented.
//  MEMADR: AluSrcA=1, AluSrcB=10, AluOP=00; next MEMRD (LW) or MEMWR (SW).
//  MEMRD: MemRead=1, IorD=1; hold until MemReady=1, then MEMWB.
//  MEMWB: RegWrite=1, RegDst=0, MemtoReg=1; next FETCH.
//  MEMWR: MemWrite=1, IorD=1; hold until MemReady=1, then FETCH.
//  EXEC: AluSrcA=1, AluSrcB=00, AluOP=10; next ALUWB.
//  ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; next FETCH.
//  BRANCH: AluSrcA=1, AluSrcB=00, AluOP=01, PCSrc=01, Branch internal=1, so PCEn=Zero; next FETCH.
//  ADDIEX: AluSrcA=1, AluSrcB=10, AluOP=00; next ADDIWB.
//  ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; next FETCH.
//  JUMP: PCSrc=10, PCWrite=1; next FETCH.
//  Unlisted outputs are 0 in each state; selects not listed are 0.
//  InstrRetired: +1 on each exit from MEMWB, ALUWB, BRANCH, ADDIWB, JUMP, or from MEMWR with MemReady=1.
//    Wraps modulo 2^CNT_W.
//  Cycles per instruction with MemReady tied high:
//    LW=5, SW=4, R=4, ADDI=4, BEQ=3, J=3. Each MemReady-low cycle adds 1.
//  Opcode is sampled only in DECODE and MEMADR; changes in other states are ignored.
// TESTING
//  Reset release, MemReady=1, Opcode=000000 -> RESET,FETCH,DECODE,EXEC(AluOP=10),ALUWB(RegWrite=1,RegDst=1), InstrRetired=1.
//  LW with MemReady=0 for 2 cycles in MEMRD -> MemRead/IorD held 3 cycles, MEMWB MemtoReg=1, total 7 cycles.
//  BEQ with Zero=1 -> BRANCH AluOP=01, PCSrc=01, PCEn=1; repeat with Zero=0 -> PCEn=0; both increment InstrRetired.
//  Opcode=6'b111111 -> DECODE->FETCH, IllegalOp high 1 cycle, InstrRetired unchanged.
//  Rst_n asserted during MEMWR -> MemWrite drops to 0 immediately; after release, RESET then FETCH.
//  Preload counter to 2^CNT_W-1 (force), retire a J -> InstrRetired=0, PCSrc=10, PCWrite=1 in JUMP.

Source files
------------

// File: rtl/multicycle_main_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_main_control_if
//  Description : Control bundle between the multicycle main control FSM
//                (master) and the MIPS datapath (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface multicycle_main_control_if #(
  parameter int unsigned CNT_W = 32
);
  // Datapath status towards the controller
  logic [5:0]       Opcode;
  logic             Zero;
  logic             MemReady;
  // Controller strobes and selects towards the datapath
  logic [1:0]       AluOP;
  logic             AluSrcA;
  logic [1:0]       AluSrcB;
  logic [1:0]       PCSrc;
  logic             PCEn;
  logic             IRWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             IorD;
  logic             RegWrite;
  logic             RegDst;
  logic             MemtoReg;
  logic             IllegalOp;
  logic [CNT_W-1:0] InstrRetired;

  modport master (
    input  Opcode, Zero, MemReady,
    output AluOP, AluSrcA, AluSrcB, PCSrc, PCEn, IRWrite, MemRead, MemWrite,
           IorD, RegWrite, RegDst, MemtoReg, IllegalOp, InstrRetired
  );

  modport slave (
    output Opcode, Zero, MemReady,
    input  AluOP, AluSrcA, AluSrcB, PCSrc, PCEn, IRWrite, MemRead, MemWrite,
           IorD, RegWrite, RegDst, MemtoReg, IllegalOp, InstrRetired
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_main_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_main_control
//  Description : Main control FSM of the multicycle MIPS datapath. Walks
//                fetch/decode/execute/memory/writeback per instruction,
//                waits on MemReady in memory states and counts retired
//                instructions.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_main_control #(
  parameter int unsigned CNT_W    = 32,
  parameter logic [5:0]  OP_RTYPE = 6'b000000,
  parameter logic [5:0]  OP_LW    = 6'b100011,
  parameter logic [5:0]  OP_SW    = 6'b101011,
  parameter logic [5:0]  OP_BEQ   = 6'b000100,
  parameter logic [5:0]  OP_ADDI  = 6'b001000,
  parameter logic [5:0]  OP_J     = 6'b000010
) (
  input  wire logic                 Clk,
  input  wire logic                 Rst_n,
  multicycle_main_control_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instr_retired_q, instr_retired_d;

  logic [1:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_write;
  logic       branch;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal_op;
  logic       retire;

  // State register; reset may land at any point of an instruction
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  // Retired-instruction counter register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) instr_retired_q <= '0;
    else        instr_retired_q <= instr_retired_d;
  end

  // Counter advances once per instruction on the edge leaving its last state
  always_comb begin
    instr_retired_d = instr_retired_q;
    if (retire) instr_retired_d = instr_retired_q + CNT_W'(1);
  end

  // Next-state and output decode; everything defaults to 0
  always_comb begin
    state_d    = state_q;
    alu_op     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal_op = 1'b0;
    retire     = 1'b0;

    unique case (state_q)
      S_RESET: state_d = S_FETCH;

      // PC+4 is computed while the instruction is read
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.MemReady;
        pc_write  = bus.MemReady;
        if (bus.MemReady) state_d = S_DECODE;
      end

      // Branch target is precomputed speculatively
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (bus.Opcode == OP_LW || bus.Opcode == OP_SW) state_d = S_MEMADR;
        else if (bus.Opcode == OP_RTYPE)                state_d = S_EXEC;
        else if (bus.Opcode == OP_BEQ)                  state_d = S_BRANCH;
        else if (bus.Opcode == OP_ADDI)                 state_d = S_ADDIEX;
        else if (bus.Opcode == OP_J)                    state_d = S_JUMP;
        else begin
          state_d    = S_FETCH;
          illegal_op = 1'b1;
        end
      end

      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (bus.MemReady) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      // A store retires only once memory accepts it
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (bus.MemReady) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end

      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end

      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end

      default: state_d = S_RESET;
    endcase
  end

  assign bus.AluOP        = alu_op;
  assign bus.AluSrcA      = alu_src_a;
  assign bus.AluSrcB      = alu_src_b;
  assign bus.PCSrc        = pc_src;
  assign bus.PCEn         = pc_write | (branch & bus.Zero);
  assign bus.IRWrite      = ir_write;
  assign bus.MemRead      = mem_read;
  assign bus.MemWrite     = mem_write;
  assign bus.IorD         = i_or_d;
  assign bus.RegWrite     = reg_write;
  assign bus.RegDst       = reg_dst;
  assign bus.MemtoReg     = mem_to_reg;
  assign bus.IllegalOp    = illegal_op;
  assign bus.InstrRetired = instr_retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_main_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_main_control
//  Description : Self-checking bench for multicycle_main_control. Each
//                instruction is expanded into its expected per-cycle output
//                sequence from the instruction-level rules, then replayed.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_main_control;

  localparam int unsigned CNT_W = 6;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic clk = 1'b0;
  logic rst_n;

  multicycle_main_control_if #(.CNT_W(CNT_W)) bus ();

  multicycle_main_control #(.CNT_W(CNT_W)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mr;
    logic        z;
    logic [5:0]  op;
    logic [15:0] exp;
    logic        ret;
    string       tag;
  } cyc_t;

  cyc_t             q[$];
  logic [CNT_W-1:0] exp_cnt;
  int               vectors;
  int               miscompares;

  // Output word: AluOP, AluSrcA, AluSrcB, PCSrc, PCEn, IRWrite, MemRead,
  // MemWrite, IorD, RegWrite, RegDst, MemtoReg, IllegalOp
  function automatic logic [15:0] mk(input logic [1:0] aop, input logic sa,
      input logic [1:0] sb, input logic [1:0] ps, input logic pcen,
      input logic irw, input logic mrd, input logic mwr, input logic iord,
      input logic rw, input logic rdst, input logic m2r, input logic ill);
    return {aop, sa, sb, ps, pcen, irw, mrd, mwr, iord, rw, rdst, m2r, ill};
  endfunction

  function automatic logic [15:0] observed();
    return {bus.AluOP, bus.AluSrcA, bus.AluSrcB, bus.PCSrc, bus.PCEn,
            bus.IRWrite, bus.MemRead, bus.MemWrite, bus.IorD, bus.RegWrite,
            bus.RegDst, bus.MemtoReg, bus.IllegalOp};
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

  task automatic check_out(input string tag, input logic [15:0] exp);
    vectors++;
    assert (observed() === exp) else begin
      miscompares++;
      $error("FAIL %s outputs observed=%b expected=%b", tag, observed(), exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [CNT_W-1:0] exp);
    vectors++;
    assert (bus.InstrRetired === exp) else begin
      miscompares++;
      $error("FAIL %s InstrRetired observed=%0d expected=%0d", tag, bus.InstrRetired, exp);
    end
  endtask

  task automatic push(input logic mr, input logic z, input logic [5:0] op,
                      input logic [15:0] e, input logic ret, input string tag);
    cyc_t c;
    c.mr = mr; c.z = z; c.op = op; c.exp = e; c.ret = ret; c.tag = tag;
    q.push_back(c);
  endtask

  // Expand one instruction: fw fetch wait cycles, mw memory wait cycles,
  // bz Zero flag presented in the branch cycle. Opcode is only meaningful in
  // DECODE/MEMADR; elsewhere it is driven with junk.
  task automatic build_instr(input logic [5:0] op, input int fw, input int mw, input logic bz);
    for (int i = 0; i < fw; i++)
      push(1'b0, rbit(), rop(), mk(2'b00,0,2'b01,2'b00,0,0,1,0,0,0,0,0,0), 1'b0, "FETCH_WAIT");
    push(1'b1, rbit(), rop(), mk(2'b00,0,2'b01,2'b00,1,1,1,0,0,0,0,0,0), 1'b0, "FETCH");
    push(rbit(), rbit(), op,
         mk(2'b00,0,2'b11,2'b00,0,0,0,0,0,0,0,0,!is_legal(op)), 1'b0, "DECODE");
    if (op == OP_LW || op == OP_SW)
      push(rbit(), rbit(), op, mk(2'b00,1,2'b10,2'b00,0,0,0,0,0,0,0,0,0), 1'b0, "MEMADR");
    if (op == OP_LW) begin
      for (int i = 0; i < mw; i++)
        push(1'b0, rbit(), rop(), mk(2'b00,0,2'b00,2'b00,0,0,1,0,1,0,0,0,0), 1'b0, "MEMRD_WAIT");
      push(1'b1, rbit(), rop(), mk(2'b00,0,2'b00,2'b00,0,0,1,0,1,0,0,0,0), 1'b0, "MEMRD");
      push(rbit(), rbit(), rop(), mk(2'b00,0,2'b00,2'b00,0,0,0,0,0,1,0,1,0), 1'b1, "MEMWB");
    end else if (op == OP_SW) begin
      for (int i = 0; i < mw; i++)
        push(1'b0, rbit(), rop(), mk(2'b00,0,2'b00,2'b00,0,0,0,1,1,0,0,0,0), 1'b0, "MEMWR_WAIT");
      push(1'b1, rbit(), rop(), mk(2'b00,0,2'b00,2'b00,0,0,0,1,1,0,0,0,0), 1'b1, "MEMWR");
    end else if (op == OP_RTYPE) begin
      push(rbit(), rbit(), rop(), mk(2'b10,1,2'b00,2'b00,0,0,0,0,0,0,0,0,0), 1'b0, "EXEC");
      push(rbit(), rbit(), rop(), mk(2'b00,0,2'b00,2'b00,0,0,0,0,0,1,1,0,0), 1'b1, "ALUWB");
    end else if (op == OP_BEQ) begin
      push(rbit(), bz, rop(), mk(2'b01,1,2'b00,2'b01,bz,0,0,0,0,0,0,0,0), 1'b1, "BRANCH");
    end else if (op == OP_ADDI) begin
      push(rbit(), rbit(), rop(), mk(2'b00,1,2'b10,2'b00,0,0,0,0,0,0,0,0,0), 1'b0, "ADDIEX");
      push(rbit(), rbit(), rop(), mk(2'b00,0,2'b00,2'b00,0,0,0,0,0,1,0,0,0), 1'b1, "ADDIWB");
    end else if (op == OP_J) begin
      push(rbit(), rbit(), rop(), mk(2'b00,0,2'b00,2'b10,1,0,0,0,0,0,0,0,0), 1'b1, "JUMP");
    end
  endtask

  // Replay up to n queued cycles; entered and left at posedge+1
  task automatic apply(input int n);
    cyc_t c;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      bus.MemReady = c.mr;
      bus.Zero     = c.z;
      bus.Opcode   = c.op;
      @(negedge clk);
      check_out(c.tag, c.exp);
      check_cnt(c.tag, exp_cnt);
      if (c.ret) exp_cnt = exp_cnt + 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_all();
    apply(q.size());
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(rbit(), rbit(), rop(), 16'h0000, 1'b0, "RESET");
  endtask

  initial begin
    logic [5:0] op;
    int         sel;
    vectors     = 0;
    miscompares = 0;
    exp_cnt     = '0;
    rst_n        = 1'b0;
    bus.MemReady = 1'b1;
    bus.Zero     = 1'b1;
    bus.Opcode   = 6'b111111;

    // Outputs held at zero throughout reset
    repeat (2) @(posedge clk);
    #1;
    check_out("RST_HOLD", 16'h0000);
    check_cnt("RST_HOLD", '0);

    // Reset release followed by an R-type with memory always ready
    release_reset();
    build_instr(OP_RTYPE, 0, 0, 1'b0);
    run_all();

    // LW with two memory wait cycles
    build_instr(OP_LW, 0, 2, 1'b0);
    run_all();

    // BEQ taken then not taken
    build_instr(OP_BEQ, 0, 0, 1'b1);
    build_instr(OP_BEQ, 0, 0, 1'b0);
    run_all();

    // Unsupported opcode
    build_instr(6'b111111, 0, 0, 1'b0);
    run_all();

    // Random instruction mix with random wait states
    for (int k = 0; k < 150; k++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: op = OP_RTYPE;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        4: op = OP_ADDI;
        5: op = OP_J;
        default: begin
          op = rop();
          while (is_legal(op)) op = rop();
        end
      endcase
      build_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), rbit());
      run_all();
    end

    // Reset asserted while a store waits in MEMWR
    build_instr(OP_SW, 0, 3, 1'b0);
    apply(4);
    bus.MemReady = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("RST_IN_MEMWR", 16'h0000);
    check_cnt("RST_IN_MEMWR", '0);
    q.delete();
    exp_cnt = '0;
    release_reset();
    build_instr(OP_ADDI, 1, 0, 1'b0);
    run_all();

    // Counter wrap: retire jumps until the count rolls over
    while (exp_cnt != {CNT_W{1'b1}}) begin
      build_instr(OP_J, 0, 0, 1'b0);
      run_all();
    end
    build_instr(OP_J, 0, 0, 1'b0);
    run_all();
    check_cnt("WRAP", '0);
    build_instr(OP_RTYPE, 0, 0, 1'b0);
    run_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
